// File: rtl/csr_hpm_counters.sv
// Hardware performance-monitor counter bank for the CSR unit.
// Counter 0 counts cycles, counter 1 counts retired instructions, counters
// 2..NUM_CNT-1 count software-selected event pulses. The 32-bit read path
// keeps a high-half snapshot so that software can read a counter without tearing.
// Optional feature macro: CSR_HPM_OVF_IRQ_EN (registered overflow interrupt).
module csr_hpm_counters #(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 64,
    parameter int EVT_W   = 8,
    localparam int IDX_W  = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
    localparam int SEL_W  = (EVT_W > 1) ? $clog2(EVT_W) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               nop,
    input  logic               mul_stall,
    input  logic [EVT_W-1:0]   evt_i,
    input  logic               csr_r_en,
    input  logic [IDX_W-1:0]   csr_r_idx,
    input  logic               csr_r_pos,
    output logic [31:0]        csr_rdata,
    output logic               csr_r_valid,
    input  logic               csr_w_en,
    input  logic [IDX_W-1:0]   csr_w_idx,
    input  logic               csr_w_pos,
    input  logic [31:0]        csr_wdata,
    input  logic               inhibit_w_en,
    input  logic [NUM_CNT-1:0] inhibit_wdata,
    input  logic               sel_w_en,
    input  logic [IDX_W-1:0]   sel_w_idx,
    input  logic [SEL_W-1:0]   sel_wdata,
    output logic [NUM_CNT-1:0] ovf_flags,
    output logic               ovf_irq
);

    localparam int HI_W = CNT_W - 32;
    localparam logic [IDX_W:0] NUM_CNT_L = (IDX_W + 1)'(NUM_CNT);

    logic [CNT_W-1:0]   cnt [NUM_CNT];
    logic [SEL_W-1:0]   evt_sel [NUM_CNT];
    logic [NUM_CNT-1:0] inhibit;
    logic [NUM_CNT-1:0] inc;
    logic [NUM_CNT-1:0] w_hit;
    logic [NUM_CNT-1:0] ovf_q;

    logic [HI_W-1:0]    snap;
    logic [IDX_W-1:0]   snap_tag;
    logic               snap_valid;
    logic               snap_load;
    logic [IDX_W-1:0]   tag_next;
    logic               sv_next;

    logic [31:0]        rdata_q;
    logic               r_valid_q;
    logic               r_in_range;
    logic [31:0]        rd_lo;
    logic [31:0]        rd_hi;

    // Per-counter increment enables and write hits
    always_comb begin
        inc   = '0;
        w_hit = '0;
        for (int unsigned k = 0; k < NUM_CNT; k++) begin
            if (k == 0) begin
                inc[k] = ~inhibit[k];
            end else if (k == 1) begin
                inc[k] = ~inhibit[k] & ~nop & ~mul_stall;
            end else if (int'(evt_sel[k]) < EVT_W) begin
                inc[k] = ~inhibit[k] & evt_i[evt_sel[k]];
            end
            w_hit[k] = csr_w_en && (csr_w_idx == IDX_W'(k));
        end
    end

    // Counter state: a write replaces one half and clears the wrap flag,
    // taking priority over a same-cycle increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < NUM_CNT; k++) begin
                cnt[k] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CNT; k++) begin
                if (w_hit[k]) begin
                    if (csr_w_pos) begin
                        cnt[k][CNT_W-1:32] <= csr_wdata[HI_W-1:0];
                    end else begin
                        cnt[k][31:0] <= csr_wdata;
                    end
                    ovf_q[k] <= 1'b0;
                end else if (inc[k]) begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                    if (&cnt[k]) begin
                        ovf_q[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // Inhibit mask and event selects; loads take effect on the following cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inhibit <= '0;
            for (int unsigned k = 0; k < NUM_CNT; k++) begin
                evt_sel[k] <= SEL_W'((k + 2 * EVT_W - 2) % EVT_W);
            end
        end else begin
            if (inhibit_w_en) begin
                inhibit <= inhibit_wdata;
            end
            if (sel_w_en) begin
                for (int unsigned k = 2; k < NUM_CNT; k++) begin
                    if (sel_w_idx == IDX_W'(k)) begin
                        evt_sel[k] <= sel_wdata;
                    end
                end
            end
        end
    end

    // Live read halves and next snapshot tag/valid
    always_comb begin
        r_in_range = {1'b0, csr_r_idx} < NUM_CNT_L;
        rd_lo      = '0;
        rd_hi      = '0;
        if (r_in_range) begin
            rd_lo = cnt[csr_r_idx][31:0];
            rd_hi = 32'(cnt[csr_r_idx][CNT_W-1:32]);
        end
        snap_load = csr_r_en & r_in_range & ~csr_r_pos;
        tag_next  = snap_load ? csr_r_idx : snap_tag;
        sv_next   = snap_load | snap_valid;
        // A same-cycle write to the tagged counter makes even a freshly
        // latched snapshot stale, so the clear wins over the load
        if ((|w_hit) && (csr_w_idx == tag_next)) begin
            sv_next = 1'b0;
        end
    end

    // Registered read response and high-half snapshot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q    <= '0;
            r_valid_q  <= 1'b0;
            snap       <= '0;
            snap_tag   <= '0;
            snap_valid <= 1'b0;
        end else begin
            r_valid_q  <= csr_r_en;
            snap_tag   <= tag_next;
            snap_valid <= sv_next;
            if (csr_r_en) begin
                if (!r_in_range) begin
                    rdata_q <= '0;
                end else if (!csr_r_pos) begin
                    rdata_q <= rd_lo;
                    snap    <= rd_hi[HI_W-1:0];
                end else if (snap_valid && (snap_tag == csr_r_idx)) begin
                    rdata_q <= 32'(snap);
                end else begin
                    rdata_q <= rd_hi;
                end
            end
        end
    end

    assign csr_rdata   = rdata_q;
    assign csr_r_valid = r_valid_q;
    assign ovf_flags   = ovf_q;

`ifdef CSR_HPM_OVF_IRQ_EN
    logic irq_q;

    // Interrupt follows the OR of the wrap flags one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |ovf_q;
        end
    end

    assign ovf_irq = irq_q;
`else
    assign ovf_irq = 1'b0;
`endif

endmodule

// File: tb/tb_csr_hpm_counters.sv
// Self-checking bench for csr_hpm_counters: a behavioural model of the
// counter bank checked every cycle, plus hand-computed directed expectations.
module tb_csr_hpm_counters;

    localparam int NUM_CNT = 4;
    localparam int CNT_W   = 64;
    localparam int EVT_W   = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         nop = 1'b0;
    logic         mul_stall = 1'b0;
    logic [7:0]   evt_i = '0;
    logic         csr_r_en = 1'b0;
    logic [1:0]   csr_r_idx = '0;
    logic         csr_r_pos = 1'b0;
    logic [31:0]  csr_rdata;
    logic         csr_r_valid;
    logic         csr_w_en = 1'b0;
    logic [1:0]   csr_w_idx = '0;
    logic         csr_w_pos = 1'b0;
    logic [31:0]  csr_wdata = '0;
    logic         inhibit_w_en = 1'b0;
    logic [3:0]   inhibit_wdata = '0;
    logic         sel_w_en = 1'b0;
    logic [1:0]   sel_w_idx = '0;
    logic [2:0]   sel_wdata = '0;
    logic [3:0]   ovf_flags;
    logic         ovf_irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csr_hpm_counters #(
        .NUM_CNT(NUM_CNT),
        .CNT_W  (CNT_W),
        .EVT_W  (EVT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .nop          (nop),
        .mul_stall    (mul_stall),
        .evt_i        (evt_i),
        .csr_r_en     (csr_r_en),
        .csr_r_idx    (csr_r_idx),
        .csr_r_pos    (csr_r_pos),
        .csr_rdata    (csr_rdata),
        .csr_r_valid  (csr_r_valid),
        .csr_w_en     (csr_w_en),
        .csr_w_idx    (csr_w_idx),
        .csr_w_pos    (csr_w_pos),
        .csr_wdata    (csr_wdata),
        .inhibit_w_en (inhibit_w_en),
        .inhibit_wdata(inhibit_wdata),
        .sel_w_en     (sel_w_en),
        .sel_w_idx    (sel_w_idx),
        .sel_wdata    (sel_wdata),
        .ovf_flags    (ovf_flags),
        .ovf_irq      (ovf_irq)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint unsigned m_cnt [NUM_CNT];
    int              m_sel [NUM_CNT];
    bit              m_inh [NUM_CNT];
    bit              m_flag[NUM_CNT];
    longint unsigned m_snap;
    int              m_tag;
    bit              m_sv;
    logic [31:0]     m_rdata;
    bit              m_rvalid;
    bit              m_irq;

    function automatic logic [3:0] model_flags();
        logic [3:0] f;
        for (int k = 0; k < NUM_CNT; k++) f[k] = m_flag[k];
        return f;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                m_cnt[k]  = 0;
                m_inh[k]  = 0;
                m_flag[k] = 0;
                m_sel[k]  = (k - 2 + EVT_W) % EVT_W;
            end
            m_snap = 0; m_tag = 0; m_sv = 0;
            m_rdata = 0; m_rvalid = 0; m_irq = 0;
        end else begin
            bit any_flag;
            bit up [NUM_CNT];
            any_flag = 0;
            for (int k = 0; k < NUM_CNT; k++) any_flag |= m_flag[k];
`ifdef CSR_HPM_OVF_IRQ_EN
            m_irq = any_flag;
`else
            m_irq = 0;
`endif
            // read sees the state before this edge's updates
            m_rvalid = csr_r_en;
            if (csr_r_en) begin
                int i;
                i = int'(csr_r_idx);
                if (i >= NUM_CNT) m_rdata = 0;
                else if (!csr_r_pos) begin
                    m_rdata = m_cnt[i] % 64'h1_0000_0000;
                    m_snap  = m_cnt[i] / 64'h1_0000_0000;
                    m_tag   = i;
                    m_sv    = 1;
                end else if (m_sv && m_tag == i) m_rdata = m_snap[31:0];
                else m_rdata = 32'(m_cnt[i] / 64'h1_0000_0000);
            end
            for (int k = 0; k < NUM_CNT; k++) begin
                if (m_inh[k]) up[k] = 0;
                else if (k == 0) up[k] = 1;
                else if (k == 1) up[k] = !nop && !mul_stall;
                else up[k] = evt_i[m_sel[k]];
            end
            for (int k = 0; k < NUM_CNT; k++) begin
                if (csr_w_en && int'(csr_w_idx) == k) begin
                    if (!csr_w_pos)
                        m_cnt[k] = (m_cnt[k] / 64'h1_0000_0000) * 64'h1_0000_0000 + longint'(csr_wdata);
                    else
                        m_cnt[k] = (m_cnt[k] % 64'h1_0000_0000) + longint'(csr_wdata) * 64'h1_0000_0000;
                    m_flag[k] = 0;
                    if (m_sv && m_tag == k) m_sv = 0;
                end else if (up[k]) begin
                    m_cnt[k] = m_cnt[k] + 1;
                    if (m_cnt[k] == 0) m_flag[k] = 1;
                end
            end
            if (inhibit_w_en)
                for (int k = 0; k < NUM_CNT; k++) m_inh[k] = inhibit_wdata[k];
            if (sel_w_en && int'(sel_w_idx) >= 2)
                m_sel[int'(sel_w_idx)] = int'(sel_wdata);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("r_valid", csr_r_valid, m_rvalid);
            if (m_rvalid) check("rdata", csr_rdata, m_rdata);
            check("ovf_flags", ovf_flags, model_flags());
            check("ovf_irq", ovf_irq, m_irq);
        end
    end

    // ---------------- stimulus helpers (entered at a negedge) ----------------
    task automatic do_write(input int idx, input bit pos, input logic [31:0] data);
        csr_w_en = 1; csr_w_idx = 2'(idx); csr_w_pos = pos; csr_wdata = data;
        @(negedge clk);
        csr_w_en = 0;
    endtask

    task automatic do_read(input int idx, input bit pos, output logic [31:0] d);
        csr_r_en = 1; csr_r_idx = 2'(idx); csr_r_pos = pos;
        @(negedge clk);
        csr_r_en = 0;
        d = csr_rdata;
    endtask

    task automatic pulse(input int e);
        evt_i = 8'(1 << e);
        @(negedge clk);
        evt_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [1:0] pat [12] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0};
    logic [31:0] d;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("reset_rdata", csr_rdata, 0);
        check("reset_rvalid", csr_r_valid, 0);
        check("reset_flags", ovf_flags, 0);
        check("reset_irq", ovf_irq, 0);

        // 100 free-running cycles
        rst = 1;
        repeat (100) @(negedge clk);
        do_read(0, 0, d); check("cycle_cnt", d, 100);
        do_read(1, 0, d); check("instret_cnt", d, 101);
        do_read(0, 1, d); check("cycle_hi", d, 0);

        // wrap of counter 2 via event 0
        do_write(2, 1, 32'hFFFF_FFFF);
        do_write(2, 0, 32'hFFFF_FFFE);
        pulse(0);
        pulse(0);
        check("wrap_flag", ovf_flags, 4'b0100);
        @(negedge clk);
`ifdef CSR_HPM_OVF_IRQ_EN
        check("wrap_irq", ovf_irq, 1);
`else
        check("wrap_irq", ovf_irq, 0);
`endif
        do_read(2, 0, d); check("wrap_value", d, 0);

        // tear-free read: snapshot taken before the carry into the high half
        do_write(0, 0, 32'hFFFF_FFFF);
        do_read(0, 0, d); check("snap_lo", d, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        do_read(0, 1, d); check("snap_hi", d, 0);
        do_read(3, 0, d);
        do_read(0, 1, d); check("live_hi", d, 1);

        // inhibit counter 1 while mul_stall toggles
        inhibit_w_en = 1; inhibit_wdata = 4'b0010;
        @(negedge clk);
        inhibit_w_en = 0;
        do_write(1, 0, 50);
        do_write(0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            mul_stall = i[0];
            @(negedge clk);
        end
        mul_stall = 0;
        do_read(0, 0, d); check("inh_cycle_runs", d, 10);
        do_read(1, 0, d); check("inh_frozen", d, 50);

        // clear inhibit and count only nop=0, mul_stall=0 cycles
        inhibit_w_en = 1; inhibit_wdata = 4'b0000;
        csr_w_en = 1; csr_w_idx = 2'd1; csr_w_pos = 0; csr_wdata = 0;
        @(negedge clk);
        inhibit_w_en = 0; csr_w_en = 0;
        for (int i = 0; i < 12; i++) begin
            {nop, mul_stall} = pat[i];
            @(negedge clk);
        end
        nop = 0; mul_stall = 0;
        do_read(1, 0, d); check("instret_gated", d, 6);

        // event select of counter 3 -> event 5
        sel_w_en = 1; sel_w_idx = 2'd3; sel_wdata = 3'd5;
        @(negedge clk);
        sel_w_en = 0;
        do_write(3, 0, 0);
        for (int i = 0; i < 7; i++) pulse(5);
        for (int i = 0; i < 4; i++) pulse(3);
        do_read(3, 0, d); check("evt_sel_cnt", d, 7);
        do_read(2, 0, d); check("evt_other", d, 0);

        // write beats wrap; read in the same cycle sees the pre-write value
        do_write(2, 1, 32'hFFFF_FFFF);
        do_write(2, 0, 32'hFFFF_FFFF);
        evt_i = 8'h01;
        csr_w_en = 1; csr_w_idx = 2'd2; csr_w_pos = 0; csr_wdata = 5;
        csr_r_en = 1; csr_r_idx = 2'd2; csr_r_pos = 0;
        @(negedge clk);
        evt_i = '0; csr_w_en = 0; csr_r_en = 0;
        check("rw_same_read", csr_rdata, 32'hFFFF_FFFF);
        check("write_beats_wrap", ovf_flags, 0);
        do_read(2, 0, d); check("write_value", d, 5);

        // set a flag, then asynchronous reset mid-cycle
        do_write(2, 0, 32'hFFFF_FFFF);
        pulse(0);
        do_read(3, 0, d); check("pre_reset_read", d, 7);
        #2 rst = 0;
        #1;
        check("async_rdata", csr_rdata, 0);
        check("async_rvalid", csr_r_valid, 0);
        check("async_flags", ovf_flags, 0);
        check("async_irq", ovf_irq, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        pulse(0);
        do_read(2, 0, d); check("post_reset_sel", d, 1);
        do_read(3, 0, d); check("post_reset_cnt3", d, 0);
        do_read(0, 0, d); check("post_reset_cycles", d, 3);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_hpm_counters.md
# csr_hpm_counters

Parametrised hardware performance-monitor counter bank for the core's CSR unit. Provides NUM_CNT counters of CNT_W bits: counter 0 counts cycles, counter 1 counts retired instructions, counters 2..NUM_CNT-1 count software-selected event pulses. Adds software writes, per-counter inhibit, a tear-free 32-bit read path with a high-half snapshot, and optional overflow interrupt. Sits between the pipeline event sources and the CSR read/write datapath.

## Interface
- NUM_CNT, 4, number of counters, 2..32
- CNT_W, 64, counter width, 33..64
- EVT_W, 8, number of event inputs, 1..32
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- nop  in  1  current retire slot is a bubble
- mul_stall  in  1  pipeline held by multiplier
- evt_i  in  EVT_W  single-cycle event pulses
- csr_r_en  in  1  read request
- csr_r_idx  in  $clog2(NUM_CNT)  counter index for read
- csr_r_pos  in  1  0 = bits 31:0, 1 = bits CNT_W-1:32
- csr_rdata  out  32  read data
- csr_r_valid  out  1  csr_rdata valid
- csr_w_en  in  1  write request
- csr_w_idx  in  $clog2(NUM_CNT)  counter index for write
- csr_w_pos  in  1  half selected for write
- csr_wdata  in  32  write data
- inhibit_w_en  in  1  load inhibit mask
- inhibit_wdata  in  NUM_CNT  new inhibit mask (1 = frozen)
- sel_w_en  in  1  load event select of counter sel_w_idx
- sel_w_idx  in  $clog2(NUM_CNT)  target counter (writes to idx 0/1 ignored)
- sel_wdata  in  $clog2(EVT_W)  event number
- ovf_flags  out  NUM_CNT  sticky per-counter wrap flags
- ovf_irq  out  1  overflow interrupt (CSR_HPM_OVF_IRQ_EN only)

## Operation
- Increment conditions (all require inhibit[k]=0): k=0 every cycle; k=1 when nop=0 and mul_stall=0; k≥2 when evt_i[evt_sel[k]]=1. Increment is +1, at most one per cycle.
- Wrap: all-ones + 1 → 0 and ovf_flags[k] set; flags stay set until that counter is written (either half), which clears it.
- Write: csr_w_pos=0 replaces bits 31:0; csr_w_pos=1 replaces bits CNT_W-1:32 with csr_wdata[CNT_W-33:0], upper wdata bits dropped. Other half unchanged. Write has priority: the increment of that counter in the same cycle is dropped.
- Read: csr_r_pos=0 returns live bits 31:0 and latches live bits CNT_W-1:32 into a snapshot register, tagging it with csr_r_idx and setting snap_valid. csr_r_pos=1 returns the snapshot if snap_valid and tag = csr_r_idx, otherwise live high bits, zero-extended to 32.
- A write to the tagged counter clears snap_valid.
- Out-of-range index (≥ NUM_CNT): read returns 0 with csr_r_valid=1, write ignored.
- evt_sel and inhibit loads take effect from the next cycle.

## Timing
- Reset values: all counters 0, ovf_flags 0, inhibit 0, evt_sel[k] = (k-2) mod EVT_W, snapshot 0, snap_valid 0, csr_rdata 0, csr_r_valid 0, ovf_irq 0.
- Reset asserted mid-operation clears all state immediately (asynchronous). Counting resumes on the first rising edge after deassertion.
- Read latency 1: request at edge N, csr_rdata and csr_r_valid at edge N+1. csr_r_valid is high for exactly one cycle per request. Back-to-back reads are supported every cycle.
- Read and write to the same counter in the same cycle: the read returns the pre-write value.
- A counter value that an increment changes at edge N is visible to a read requested in cycle N+1.
- Simultaneous write and wrap on the same counter: the write wins, and ovf_flags is cleared.

## Configuration
- CSR_HPM_OVF_IRQ_EN defined: ovf_irq is a register, equal to OR of ovf_flags delayed one cycle.
- CSR_HPM_OVF_IRQ_EN not defined: ovf_irq is tied 0 and its register is removed. ovf_flags are still maintained.

## Test plan
- Reset, then run 100 cycles with nop=0, mul_stall=0. Read idx0 pos0 → 100 (±1 at the read edge). Read idx1 pos0 → same value. Read pos1 → 0.
- Write idx2 high=0xFFFFFFFF and low=0xFFFFFFFE. Pulse the selected event twice → counter = 0, ovf_flags[2]=1, ovf_irq=1 one cycle later (macro on) or ovf_irq held 0 (macro off).
- Write idx0 low=0xFFFFFFFF. Read pos0 at edge N, then pos1 at edge N+3 → pos1 returns 0, the snapshot value, not the live value 1.
- Set inhibit=4'b0010 with mul_stall toggling → counter 1 frozen, counter 0 still advancing. Clear inhibit → counter 1 counts only cycles with nop=0 and mul_stall=0.
- Set sel_w_idx=3, sel_wdata=5. Pulse evt_i[5] ×7 and evt_i[3] ×4 → counter 3 = 7.
- Assert rst mid-count → all outputs 0 within the same cycle, without waiting for a clock edge.
